if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and decode; replaces a bare IF/ID latch.
//  Buffers {instruction, incPC} pairs so a decode stall does not drop a fetched word.
//  Flushes on a resolved branch.
//  Stops accepting fetches after a HALT is enqueued.
//  Drives a NOP to decode whenever the queue is empty.
// PARAMETERS
//  DEPTH      2         entries; power of 2, >= 2
//  WIDTH      16        instruction and PC width
//  NOP_INSTR  16'h0800  word presented to decode when empty
//  HALT_INSTR 16'h0000  word that blocks further enqueue
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  fetchValid   in   1      fetch presents an instruction this cycle
//  fetchInstr   in   WIDTH  instruction word from fetch
//  fetchIncPC   in   WIDTH  PC+2 of that instruction
//  fetchReady   out  1      queue accepts a push this cycle
//  flush        in   1      branch/jump resolved taken; discard all entries
//  decodeReady  in   1      decode consumes the head this cycle
//  decodeValid  out  1      head entry valid
//  decodeInstr  out  WIDTH  head instruction, or NOP_INSTR when empty
//  decodeIncPC  out  WIDTH  head PC+2, or 0 when empty
//  err          out  1      sticky internal-consistency error
// BEHAVIOUR
//  - Reset (rst=0, async), all outputs:
//    - count=0, rdPtr=wrPtr=0, haltSeen=0, err=0.
//    - decodeValid=0, decodeInstr=NOP_INSTR, decodeIncPC=0, fetchReady=1.
//    - Reset asserted mid-operation discards all entries immediately.
//  - push = fetchValid & fetchReady.
//  - pop = decodeReady & decodeValid.
//  - fetchReady = (count < DEPTH) & ~haltSeen. Combinational; does not depend on pop in the same cycle.
//  - Storage is registered. An entry pushed at edge N is visible on decode outputs after edge N.
//    Minimum latency is 1 cycle; there is no fall-through.
//  - Decode outputs are combinational from the head entry.
//    decodeValid = (count != 0).
//  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
//  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
//  - When count == DEPTH, a push is refused (fetchReady=0) even if a pop occurs the same cycle.
//    Fetch must hold its PC; this cycle is a stall.
//  - Flush has priority over push and pop in the same cycle:
//    - At the edge: count=0, rdPtr=wrPtr=0, haltSeen=0.
//    - The pushed word in that cycle is dropped.
//    - Next cycle: decodeValid=0.
//  - HALT: a push of HALT_INSTR sets haltSeen at the same edge.
//    - haltSeen clears only on flush or reset.
//    - Entries already queued still drain normally.
//  - err is set, and held until reset, when:
//    - count > DEPTH, or
//    - (count == 0) & (rdPtr != wrPtr).
//    Otherwise err=0. Queue operation continues regardless.
//  - No state machine beyond count/pointers/haltSeen. States: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
//    - EMPTY→PARTIAL on push.
//    - FULL→PARTIAL on pop.
//    - Any state→EMPTY on flush.
// STRUCTURE
//  - Shared package wisc_pkg holds:
//    - localparams OPC_NOP=16'h0800 and OPC_HALT=16'h0000;
//    - typedef ifq_entry_t = struct {instr[15:0], incPC[15:0]}.
//  - One sub-module, ifq_storage: DEPTH x 2*WIDTH register array.
//    - One write port (wrEn, wrAddr) and one combinational read port (rdAddr).
//    - Async active-low reset to zero.
//  - Control (pointers, count, haltSeen, err) lives in if_id_queue itself.
// TESTING
//  1. Reset: rst=0 for 2 cycles → decodeValid=0, decodeInstr=16'h0800, decodeIncPC=0, fetchReady=1, err=0.
//  2. Fill with decodeReady=0: push 16'h4A21/PC 16'h0002, then 16'h4B22/PC 16'h0004.
//     → fetchReady=0 after the second edge; head=16'h4A21. A third push of 16'h4C23 is not accepted.
//  3. Drain: from FULL, decodeReady=1 for 2 cycles.
//     → head 16'h4A21 then 16'h4B22; then decodeValid=0, decodeInstr=16'h0800.
//  4. Streaming: fetchValid=1 and decodeReady=1 every cycle for 8 words 16'h1000..16'h1007 (pointer wrap).
//     → decode sees the words in order, each one cycle after its push; count stays 1; err=0.
//  5. Flush collision: count=2, then flush=1 with fetchValid=1 (16'h5555) and decodeReady=1 in the same cycle.
//     → next cycle count=0, decodeValid=0; 16'h5555 never appears at decode.
//  6. HALT: push 16'h0000 then attempt 16'h2222.
//     → fetchReady=0 after the HALT edge; HALT drains to decode.
//     → Flush restores fetchReady=1. Async rst pulse mid-fill clears count without a clock edge.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: opcode constants and the
// instruction-queue entry layout.
package wisc_pkg;

  localparam logic [15:0] OPC_NOP  = 16'h0800;
  localparam logic [15:0] OPC_HALT = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] incPC;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Register array backing the IF/ID queue: one write port, one combinational
// read port, cleared by the asynchronous active-low reset.
module ifq_storage #(
  parameter  int DEPTH  = 2,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: buffers {instr, incPC} pairs,
// flushes on a taken branch, stops accepting after HALT, shows NOP when empty.
module if_id_queue
  import wisc_pkg::*;
#(
  parameter int               DEPTH      = 2,
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR  = OPC_NOP,
  parameter logic [WIDTH-1:0] HALT_INSTR = OPC_HALT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetchValid,
  input  logic [WIDTH-1:0] fetchInstr,
  input  logic [WIDTH-1:0] fetchIncPC,
  output logic             fetchReady,
  input  logic             flush,
  input  logic             decodeReady,
  output logic             decodeValid,
  output logic [WIDTH-1:0] decodeInstr,
  output logic [WIDTH-1:0] decodeIncPC,
  output logic             err
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   rdPtr, wrPtr;
  logic [CNT_W-1:0]   count;
  logic               haltSeen, errQ, errCond;
  logic               push, pop;
  logic [2*WIDTH-1:0] headData;

  // Full refuses a push even when decode pops the same cycle, so fetchReady
  // never depends on decodeReady.
  assign fetchReady  = (count < DEPTH_C) & ~haltSeen;
  assign decodeValid = (count != '0);
  assign push        = fetchValid & fetchReady;
  assign pop         = decodeReady & decodeValid;

  assign errCond = (count > DEPTH_C) | ((count == '0) & (rdPtr != wrPtr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      haltSeen <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      errQ <= errQ | errCond;
      if (flush) begin
        count    <= '0;
        rdPtr    <= '0;
        wrPtr    <= '0;
        haltSeen <= 1'b0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (push && (fetchInstr == HALT_INSTR)) haltSeen <= 1'b1;
      end
    end
  end

  assign err = errQ;

  ifq_storage #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * WIDTH)
  ) uStorage (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (push & ~flush),
    .wrAddr (wrPtr),
    .wrData ({fetchInstr, fetchIncPC}),
    .rdAddr (rdPtr),
    .rdData (headData)
  );

  assign decodeInstr = decodeValid ? headData[2*WIDTH-1:WIDTH] : NOP_INSTR;
  assign decodeIncPC = decodeValid ? headData[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table for fill/drain/flush/HALT,
// scoreboard for streaming, and an asynchronous reset pulse mid-fill.
module tb_if_id_queue;
  import wisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetchValid = 1'b0;
  logic [15:0] fetchInstr = '0;
  logic [15:0] fetchIncPC = '0;
  logic        fetchReady;
  logic        flush = 1'b0;
  logic        decodeReady = 1'b0;
  logic        decodeValid;
  logic [15:0] decodeInstr;
  logic [15:0] decodeIncPC;
  logic        err;

  int nCmp  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk         (clk),
    .rst         (rst),
    .fetchValid  (fetchValid),
    .fetchInstr  (fetchInstr),
    .fetchIncPC  (fetchIncPC),
    .fetchReady  (fetchReady),
    .flush       (flush),
    .decodeReady (decodeReady),
    .decodeValid (decodeValid),
    .decodeInstr (decodeInstr),
    .decodeIncPC (decodeIncPC),
    .err         (err)
  );

  typedef struct {
    logic        fv;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        fl;
    logic        dr;
    logic        expValid;
    logic [15:0] expInstr;
    logic [15:0] expPC;
    logic        expReady;
  } vec_t;

  vec_t       vecs [20];
  ifq_entry_t sbq [$];
  ifq_entry_t head;
  logic       expValid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [15:0] ins, input logic [15:0] pc,
                       input logic fl, input logic dr);
    fetchValid  = fv;
    fetchInstr  = ins;
    fetchIncPC  = pc;
    flush       = fl;
    decodeReady = dr;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h4A21, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    vecs[1]  = '{1'b1, 16'h4B22, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h4A21, 16'h0002, 1'b1};
    vecs[2]  = '{1'b1, 16'h4C23, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h4A21, 16'h0002, 1'b0};
    vecs[3]  = '{1'b1, 16'h4C23, 16'h0006, 1'b0, 1'b1, 1'b1, 16'h4A21, 16'h0002, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h4B22, 16'h0004, 1'b1};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    vecs[6]  = '{1'b1, 16'h6001, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 16'h6002, 16'h0012, 1'b0, 1'b0, 1'b1, 16'h6001, 16'h0010, 1'b1};
    vecs[8]  = '{1'b1, 16'h5555, 16'h0014, 1'b1, 1'b1, 1'b1, 16'h6001, 16'h0010, 1'b0};
    vecs[9]  = '{1'b1, 16'h7001, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 16'h5555, 16'h0022, 1'b1, 1'b1, 1'b1, 16'h7001, 16'h0020, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    vecs[12] = '{1'b1, 16'h0000, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    vecs[13] = '{1'b1, 16'h2222, 16'h0032, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0030, 1'b0};
    vecs[14] = '{1'b1, 16'h2222, 16'h0032, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0030, 1'b0};
    vecs[15] = '{1'b1, 16'h2222, 16'h0032, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b0};
    vecs[17] = '{1'b1, 16'h3333, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    vecs[18] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h3333, 16'h0040, 1'b1};
    vecs[19] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.decodeValid", 32'(decodeValid), 32'(1'b0));
    chk("rst.decodeInstr", 32'(decodeInstr), 32'(16'h0800));
    chk("rst.decodeIncPC", 32'(decodeIncPC), 32'(16'h0000));
    chk("rst.fetchReady",  32'(fetchReady),  32'(1'b1));
    chk("rst.err",         32'(err),         32'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill, full-with-pop, drain, flush collisions, HALT
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].fv, vecs[i].instr, vecs[i].pc, vecs[i].fl, vecs[i].dr);
      @(negedge clk);
      chk($sformatf("vec%0d.decodeValid", i), 32'(decodeValid), 32'(vecs[i].expValid));
      chk($sformatf("vec%0d.decodeInstr", i), 32'(decodeInstr), 32'(vecs[i].expInstr));
      chk($sformatf("vec%0d.decodeIncPC", i), 32'(decodeIncPC), 32'(vecs[i].expPC));
      chk($sformatf("vec%0d.fetchReady", i),  32'(fetchReady),  32'(vecs[i].expReady));
      chk($sformatf("vec%0d.err", i),         32'(err),         32'(1'b0));
      @(posedge clk);
      #1;
    end

    // Streaming through pointer wrap: each word reaches decode one cycle after its push
    for (int k = 0; k <= 8; k++) begin
      drive(k < 8, 16'h1000 + 16'(k), 16'h0100 + 16'(2 * k), 1'b0, 1'b1);
      @(negedge clk);
      expValid = (sbq.size() != 0);
      chk($sformatf("stream%0d.decodeValid", k), 32'(decodeValid), 32'(expValid));
      if (expValid) begin
        head = sbq.pop_front();
        chk($sformatf("stream%0d.decodeInstr", k), 32'(decodeInstr), 32'(head.instr));
        chk($sformatf("stream%0d.decodeIncPC", k), 32'(decodeIncPC), 32'(head.incPC));
      end
      chk($sformatf("stream%0d.fetchReady", k), 32'(fetchReady), 32'(1'b1));
      chk($sformatf("stream%0d.err", k),        32'(err),        32'(1'b0));
      @(posedge clk);
      if (k < 8) sbq.push_back('{instr: 16'h1000 + 16'(k), incPC: 16'h0100 + 16'(2 * k)});
      #1;
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream.end.decodeValid", 32'(decodeValid), 32'(1'b0));

    // Async reset pulse mid-fill, between clock edges
    @(posedge clk);
    #1;
    drive(1'b1, 16'h8001, 16'h0050, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h8002, 16'h0052, 1'b0, 1'b0);
    @(negedge clk);
    chk("arst.pre.decodeInstr", 32'(decodeInstr), 32'(16'h8001));
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst.decodeValid", 32'(decodeValid), 32'(1'b0));
    chk("arst.decodeInstr", 32'(decodeInstr), 32'(16'h0800));
    chk("arst.decodeIncPC", 32'(decodeIncPC), 32'(16'h0000));
    chk("arst.fetchReady",  32'(fetchReady),  32'(1'b1));
    #1 rst = 1'b1;
    @(negedge clk);
    chk("arst.post.decodeValid", 32'(decodeValid), 32'(1'b0));
    chk("arst.post.err",         32'(err),         32'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
